dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Front-end controller for the 8-bit true dual-port RAM: accepts read/write requests from two independent requesters (A, B), clears the RAM after reset, serialises same-address collisions with round-robin priority, and returns one response per accepted request. Sits between system masters and the RAM's two ports; it is the only driver of the RAM's control, address and data inputs.

## Interface
- AW, 8, address width
- DW, 8, data width
- DEPTH, 20, valid RAM locations (addresses 0..DEPTH-1)
- INIT_CYCLES, 2, cycles ram_rst is held after reset release (>=1)

- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- a_valid / b_valid  in  1  request valid
- a_ready / b_ready  out  1  request accepted when valid&&ready at posedge
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  AW  request address
- a_wdata / b_wdata  in  DW  write data
- a_resp_valid / b_resp_valid  out  1  one-cycle response pulse
- a_resp_rdata / b_resp_rdata  out  DW  read data (0 for writes/errors)
- a_resp_err / b_resp_err  out  1  address >= DEPTH
- ram_rst  out  1  RAM synchronous clear
- ram_we_a / ram_we_b  out  1  RAM write enables
- ram_add_a / ram_add_b  out  AW  RAM addresses
- ram_data_a / ram_data_b  out  DW  RAM write data
- ram_read_a / ram_read_b  in  DW  RAM registered read data
- conflict_cnt  out  16  collision counter (see Configuration)

## Operation
- FSM: INIT -> RUN. Reset enters INIT; INIT asserts ram_rst, ready=0, counts INIT_CYCLES posedges, then RUN. RUN is permanent until rst.
- In RUN, a port is "live" when its valid=1. Grant logic (combinational from live requests):
  - Collision = both live, same address, at least one write. Grant only the port indicated by rr_ptr; other port ready=0. rr_ptr flips to the other port on each collision grant; non-collision cycles leave rr_ptr unchanged. rr_ptr resets to A.
  - Otherwise every live port is granted (ready=1), including both-read same address.
- Out-of-range (addr >= DEPTH): granted per above rules but not forwarded to RAM (that port treated idle for RAM drive); response has err=1, rdata=0.
- RAM drive for granted in-range ports: ram_we_x=we, ram_add_x=addr, ram_data_x=wdata.
- Idle port (not granted, out-of-range, or not live) mirrors the active port: ram_add and ram_data equal the other port's values, ram_we=0. Both idle: all RAM outputs 0. Mirroring is mandatory: the RAM's port-B write path stores data_a when addresses match.
- Read data routing: RAM returns a port-B read on ram_read_a whenever ram_add_a==ram_add_b. Controller registers that equality with the grant; if set, b_resp_rdata = ram_read_a, else ram_read_b. a_resp_rdata always ram_read_a.
- Writes produce a response with rdata=0, err=0.

## Timing
- Reset values: all ready, resp_valid, resp_err, ram_we_*=0; ram_rst=1; addresses/data 0; rr_ptr=A; conflict_cnt=0.
- ram_rst deasserts after the INIT_CYCLES-th posedge following rst release; ready can first be 1 the next cycle.
- Latency: request accepted at edge N -> resp_valid=1 for the single cycle after edge N, rdata valid in that cycle. Fully pipelined: one request per port per cycle.
- ready is combinational from valid/addr/we; requester must hold request stable while valid&&!ready.
- Stalled port waits at most one cycle under continuous collision (rr alternation).
- rst asserted mid-operation: pending responses dropped immediately, FSM returns to INIT, RAM re-cleared.

## Configuration
- DPRAM_ARB_STATS_EN defined: conflict_cnt increments by 1 on each RUN cycle with a collision, saturates at 16'hFFFF, cleared by rst.
- Not defined: counter logic absent, conflict_cnt tied to 0.

## Test plan
- Reset release, INIT_CYCLES=2 -> ram_rst high 2 edges, ready low during INIT; read A addr 5 afterwards -> rdata 0x00.
- A writes 0x3C to addr 7 and B writes 0xA5 to addr 9 same cycle -> both ready, both resp next cycle; subsequent reads return 0x3C / 0xA5.
- A and B write addr 4 (0x11 / 0x22) held valid -> A granted first, B next cycle; read addr 4 = 0x22; conflict_cnt = 1 (EN build).
- Preload addr 3 = 0x5A; A and B read addr 3 same cycle -> both granted, both rdata 0x5A.
- A write addr 12 = 0x77 with B idle -> ram_add_b=12, ram_data_b=0x77, ram_we_b=0; B then reads 12 -> 0x77.
- B read addr 25 -> b_resp_err=1, rdata 0, ram_we_* 0; rst pulse mid-stream -> no resp_valid after rst, RAM re-cleared.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter
//
// Front-end controller for the 8-bit true dual-port RAM. Two independent
// requesters (A and B) issue read/write requests; the controller clears the
// RAM after reset, serialises same-address collisions with a round-robin
// pointer and returns exactly one response per accepted request, one cycle
// after acceptance.
//
// Optional feature macro: DPRAM_ARB_STATS_EN
//    defined     -> conflict_cnt counts collision cycles (saturating)
//    not defined -> conflict_cnt is tied to zero
//
// Ports
//    clk, rst                     clock, asynchronous active-high reset
//    a_valid/a_ready, a_we,       requester A handshake and request fields
//    a_addr, a_wdata
//    a_resp_valid, a_resp_rdata,  requester A one-cycle response
//    a_resp_err
//    b_*                          same set for requester B
//    ram_rst                      synchronous clear to the RAM
//    ram_we_x, ram_add_x,         RAM port x write enable / address / data
//    ram_data_x
//    ram_read_a, ram_read_b       RAM registered read data
//    conflict_cnt                 collision statistics counter
// ---------------------------------------------------------------------------
module dpram_port_arbiter #(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int DEPTH       = 20,
   parameter int INIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          a_resp_valid,
   output logic [DW-1:0] a_resp_rdata,
   output logic          a_resp_err,
   output logic          b_resp_valid,
   output logic [DW-1:0] b_resp_rdata,
   output logic          b_resp_err,
   output logic          ram_rst,
   output logic          ram_we_a,
   output logic          ram_we_b,
   output logic [AW-1:0] ram_add_a,
   output logic [AW-1:0] ram_add_b,
   output logic [DW-1:0] ram_data_a,
   output logic [DW-1:0] ram_data_b,
   input  logic [DW-1:0] ram_read_a,
   input  logic [DW-1:0] ram_read_b,
   output logic [15:0]   conflict_cnt
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam int            CW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] init_cnt;
   logic          run;

   logic          rr_ptr;
   logic          collision;
   logic          a_in_range;
   logic          b_in_range;
   logic          a_drive;
   logic          b_drive;

   logic          a_rd_pending;
   logic          b_rd_pending;
   logic          b_from_a;

   // State register: reset always lands in INIT so the RAM is cleared again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   // Counts the posedges spent in INIT; holds its final value once RUN is
   // reached, and only a reset brings it back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt <= '0;
      end else if (state == ST_INIT && init_cnt != INIT_LAST) begin
         init_cnt <= init_cnt + CW'(1);
      end
   end

   // Next-state logic: INIT lasts exactly INIT_CYCLES edges, RUN is sticky.
   always_comb begin
      state_next = state;
      case (state)
         ST_INIT: if (init_cnt == INIT_LAST) state_next = ST_RUN;
         ST_RUN:  state_next = ST_RUN;
         default: state_next = ST_INIT;
      endcase
   end

   // FSM outputs: the RAM is held in clear for the whole INIT phase and no
   // request can be accepted until RUN.
   always_comb begin
      run     = (state == ST_RUN);
      ram_rst = (state == ST_INIT);
   end

   // Grant logic. A collision is two live requests to one address where at
   // least one writes; only the round-robin favourite (0 = A, 1 = B) wins.
   // Out-of-range requests are still granted so they can be answered with an
   // error, but they never reach the RAM.
   always_comb begin
      collision  = a_valid && b_valid && (a_addr == b_addr) && (a_we || b_we);
      a_ready    = run && a_valid && (!collision || !rr_ptr);
      b_ready    = run && b_valid && (!collision || rr_ptr);
      a_in_range = ({1'b0, a_addr} < DEPTH_L);
      b_in_range = ({1'b0, b_addr} < DEPTH_L);
      a_drive    = a_ready && a_in_range;
      b_drive    = b_ready && b_in_range;
   end

   // RAM port drive. An idle port copies the address and data of the active
   // port with its write enable low: the RAM's port-B write path takes
   // data_a when the addresses match, so the two ports must never disagree.
   always_comb begin
      ram_we_a   = 1'b0;
      ram_add_a  = '0;
      ram_data_a = '0;
      ram_we_b   = 1'b0;
      ram_add_b  = '0;
      ram_data_b = '0;
      if (a_drive) begin
         ram_we_a   = a_we;
         ram_add_a  = a_addr;
         ram_data_a = a_wdata;
      end else if (b_drive) begin
         ram_add_a  = b_addr;
         ram_data_a = b_wdata;
      end
      if (b_drive) begin
         ram_we_b   = b_we;
         ram_add_b  = b_addr;
         ram_data_b = b_wdata;
      end else if (a_drive) begin
         ram_add_b  = a_addr;
         ram_data_b = a_wdata;
      end
   end

   // Round-robin pointer flips only on cycles that actually arbitrate a
   // collision, so a stalled port is served on the very next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (run && collision) begin
         rr_ptr <= ~rr_ptr;
      end
   end

   // Response pipeline. Everything accepted at one edge is answered in the
   // following cycle. The address-equality flag is captured alongside the
   // grant because the RAM reports a port-B read on ram_read_a whenever both
   // RAM addresses were equal.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_resp_valid <= 1'b0;
         a_resp_err   <= 1'b0;
         a_rd_pending <= 1'b0;
         b_resp_valid <= 1'b0;
         b_resp_err   <= 1'b0;
         b_rd_pending <= 1'b0;
         b_from_a     <= 1'b0;
      end else begin
         a_resp_valid <= a_ready;
         a_resp_err   <= a_ready && !a_in_range;
         a_rd_pending <= a_drive && !a_we;
         b_resp_valid <= b_ready;
         b_resp_err   <= b_ready && !b_in_range;
         b_rd_pending <= b_drive && !b_we;
         b_from_a     <= (ram_add_a == ram_add_b);
      end
   end

   // Read data is only presented for in-range reads; writes and errors
   // answer with zero.
   always_comb begin
      a_resp_rdata = '0;
      b_resp_rdata = '0;
      if (a_rd_pending) begin
         a_resp_rdata = ram_read_a;
      end
      if (b_rd_pending) begin
         b_resp_rdata = b_from_a ? ram_read_a : ram_read_b;
      end
   end

`ifdef DPRAM_ARB_STATS_EN
   // Collision statistics: one count per arbitrated cycle, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (run && collision && conflict_cnt != 16'hFFFF) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`else
   assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dpram_port_arbiter
//
// Self-checking bench for dpram_port_arbiter. Contains a behavioural model of
// the dual-port RAM (including its same-address quirks) and a reference
// model of the controller built from the arbitration rules: a plain memory
// array, a round-robin flag and a collision count.
// ---------------------------------------------------------------------------
module tb_dpram_port_arbiter;

   localparam int AW          = 8;
   localparam int DW          = 8;
   localparam int DEPTH       = 20;
   localparam int INIT_CYCLES = 2;

`ifdef DPRAM_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_ready;
   logic          a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic          b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic          a_resp_valid;
   logic [DW-1:0] a_resp_rdata;
   logic          a_resp_err;
   logic          b_resp_valid;
   logic [DW-1:0] b_resp_rdata;
   logic          b_resp_err;
   logic          ram_rst;
   logic          ram_we_a;
   logic          ram_we_b;
   logic [AW-1:0] ram_add_a;
   logic [AW-1:0] ram_add_b;
   logic [DW-1:0] ram_data_a;
   logic [DW-1:0] ram_data_b;
   logic [DW-1:0] ram_read_a;
   logic [DW-1:0] ram_read_b;
   logic [15:0]   conflict_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_ref [DEPTH];
   bit         rr_ref;
   int         cnt_ref;

   logic [7:0] ram_mem [256];
   bit         ram_filled = 1'b0;

   dpram_port_arbiter #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .INIT_CYCLES(INIT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata), .a_resp_err(a_resp_err),
      .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata), .b_resp_err(b_resp_err),
      .ram_rst(ram_rst), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
      .ram_add_a(ram_add_a), .ram_add_b(ram_add_b),
      .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
      .ram_read_a(ram_read_a), .ram_read_b(ram_read_b),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // RAM model. First edge fills it with junk so that a missing clear shows
   // up. With equal addresses a port-B write stores data_a, the port-B read
   // is delivered on ram_read_a and ram_read_b carries inverted junk.
   always @(posedge clk) begin
      if (!ram_filled) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i * 37 + 1);
         ram_filled <= 1'b1;
      end else if (ram_rst) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
         ram_read_a <= 8'h00;
         ram_read_b <= 8'h00;
      end else begin
         if (ram_we_a) ram_mem[ram_add_a] <= ram_data_a;
         if (ram_we_b) ram_mem[ram_add_b] <= (ram_add_a == ram_add_b) ? ram_data_a : ram_data_b;
         ram_read_a <= ram_mem[ram_add_a];
         ram_read_b <= (ram_add_a == ram_add_b) ? ~ram_mem[ram_add_b] : ram_mem[ram_add_b];
      end
   end

   // Watchdog so the bench always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Asserts reset (with an immediate check that pending responses vanish),
   // walks through INIT checking that nothing is accepted, then resets the
   // reference model to a cleared memory.
   task automatic doReset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst     = 1'b1;
      #1;
      checkOutput("rst_a_resp_valid", 32'(a_resp_valid), 32'd0);
      checkOutput("rst_b_resp_valid", 32'(b_resp_valid), 32'd0);
      checkOutput("rst_ram_rst", 32'(ram_rst), 32'd1);
      checkOutput("rst_ram_add_a", 32'(ram_add_a), 32'd0);
      checkOutput("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < INIT_CYCLES; i++) begin
         a_valid = 1'b1;
         a_we    = 1'b0;
         a_addr  = 8'(i);
         b_valid = 1'b1;
         b_we    = 1'b1;
         b_addr  = 8'(i + 1);
         #1;
         checkOutput("init_ram_rst", 32'(ram_rst), 32'd1);
         checkOutput("init_a_ready", 32'(a_ready), 32'd0);
         checkOutput("init_b_ready", 32'(b_ready), 32'd0);
         checkOutput("init_ram_we_b", 32'(ram_we_b), 32'd0);
         @(posedge clk);
         #1;
         checkOutput("init_a_resp_valid", 32'(a_resp_valid), 32'd0);
         checkOutput("init_b_resp_valid", 32'(b_resp_valid), 32'd0);
      end
      checkOutput("run_ram_rst", 32'(ram_rst), 32'd0);
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_ref[i] = 8'h00;
      rr_ref  = 1'b0;
      cnt_ref = 0;
   endtask

   // One bus cycle: drive both requesters, check grants and RAM drive
   // before the edge, advance the reference model, then check the responses
   // after the edge.
   task automatic applyStimulus(input logic av, input logic awe, input logic [7:0] aad,
                                input logic [7:0] awd, input logic bv, input logic bwe,
                                input logic [7:0] bad, input logic [7:0] bwd,
                                output logic ga, output logic gb);
      logic       coll, ina, inb, act_a, act_b;
      logic       ev_a, ee_a, ev_b, ee_b;
      logic [7:0] er_a, er_b;
      a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
      b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
      #1;
      coll  = av && bv && (aad == bad) && (awe || bwe);
      ga    = av && (!coll || !rr_ref);
      gb    = bv && (!coll || rr_ref);
      ina   = int'(aad) < DEPTH;
      inb   = int'(bad) < DEPTH;
      act_a = ga && ina;
      act_b = gb && inb;
      checkOutput("a_ready", 32'(a_ready), 32'(ga));
      checkOutput("b_ready", 32'(b_ready), 32'(gb));
      checkOutput("ram_we_a", 32'(ram_we_a), 32'(act_a && awe));
      checkOutput("ram_we_b", 32'(ram_we_b), 32'(act_b && bwe));
      checkOutput("ram_add_a", 32'(ram_add_a), 32'(act_a ? aad : (act_b ? bad : 8'h00)));
      checkOutput("ram_add_b", 32'(ram_add_b), 32'(act_b ? bad : (act_a ? aad : 8'h00)));
      checkOutput("ram_data_a", 32'(ram_data_a), 32'(act_a ? awd : (act_b ? bwd : 8'h00)));
      checkOutput("ram_data_b", 32'(ram_data_b), 32'(act_b ? bwd : (act_a ? awd : 8'h00)));
      checkOutput("conflict_cnt", 32'(conflict_cnt), STATS ? 32'(cnt_ref) : 32'd0);

      ev_a = ga;
      ee_a = ga && !ina;
      er_a = (act_a && !awe) ? mem_ref[int'(aad)] : 8'h00;
      ev_b = gb;
      ee_b = gb && !inb;
      er_b = (act_b && !bwe) ? mem_ref[int'(bad)] : 8'h00;
      if (act_a && awe) mem_ref[int'(aad)] = awd;
      if (act_b && bwe) mem_ref[int'(bad)] = bwd;
      if (coll) begin
         rr_ref = !rr_ref;
         if (cnt_ref < 65535) cnt_ref++;
      end

      @(posedge clk);
      #1;
      checkOutput("a_resp_valid", 32'(a_resp_valid), 32'(ev_a));
      checkOutput("a_resp_err", 32'(a_resp_err), 32'(ee_a));
      checkOutput("a_resp_rdata", 32'(a_resp_rdata), 32'(er_a));
      checkOutput("b_resp_valid", 32'(b_resp_valid), 32'(ev_b));
      checkOutput("b_resp_err", 32'(b_resp_err), 32'(ee_b));
      checkOutput("b_resp_rdata", 32'(b_resp_rdata), 32'(er_b));
   endtask

   function automatic logic [7:0] randAddr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 8'($urandom_range(DEPTH, DEPTH + 12));
      if (r < 6)  return 8'($urandom_range(0, 3));
      return 8'($urandom_range(0, DEPTH - 1));
   endfunction

   // Random traffic; a port that was not granted holds its request.
   task automatic randomTraffic(input int cycles);
      logic       av, awe, bv, bwe, ga, gb, hold_a, hold_b;
      logic [7:0] aad, awd, bad, bwd;
      hold_a = 1'b0; hold_b = 1'b0;
      av = 1'b0; awe = 1'b0; aad = 8'h00; awd = 8'h00;
      bv = 1'b0; bwe = 1'b0; bad = 8'h00; bwd = 8'h00;
      for (int i = 0; i < cycles; i++) begin
         if (!hold_a) begin
            av  = ($urandom_range(0, 3) != 0);
            awe = $urandom_range(0, 1) == 1;
            aad = randAddr();
            awd = 8'($urandom);
         end
         if (!hold_b) begin
            bv  = ($urandom_range(0, 3) != 0);
            bwe = $urandom_range(0, 1) == 1;
            bad = randAddr();
            bwd = 8'($urandom);
         end
         applyStimulus(av, awe, aad, awd, bv, bwe, bad, bwd, ga, gb);
         hold_a = av && !ga;
         hold_b = bv && !gb;
      end
   endtask

   initial begin
      logic ga, gb;
      #2;
      doReset();

      // Cleared RAM reads back zero.
      applyStimulus(1, 0, 8'd5, 8'h00, 0, 0, 8'd0, 8'h00, ga, gb);

      // Independent writes, then read back.
      applyStimulus(1, 1, 8'd7, 8'h3C, 1, 1, 8'd9, 8'hA5, ga, gb);
      applyStimulus(1, 0, 8'd7, 8'h00, 1, 0, 8'd9, 8'h00, ga, gb);

      // Write/write collision on address 4: A first, B the next cycle.
      applyStimulus(1, 1, 8'd4, 8'h11, 1, 1, 8'd4, 8'h22, ga, gb);
      checkOutput("coll_first_b_stalled", 32'(gb), 32'd0);
      applyStimulus(0, 0, 8'd0, 8'h00, 1, 1, 8'd4, 8'h22, ga, gb);
      applyStimulus(1, 0, 8'd4, 8'h00, 0, 0, 8'd0, 8'h00, ga, gb);

      // Both ports reading the same address.
      applyStimulus(1, 1, 8'd3, 8'h5A, 0, 0, 8'd0, 8'h00, ga, gb);
      applyStimulus(1, 0, 8'd3, 8'h00, 1, 0, 8'd3, 8'h00, ga, gb);

      // Single writer with B idle (mirroring), then B reads it.
      applyStimulus(1, 1, 8'd12, 8'h77, 0, 0, 8'd0, 8'h00, ga, gb);
      applyStimulus(0, 0, 8'd0, 8'h00, 1, 0, 8'd12, 8'h00, ga, gb);

      // Out-of-range access, including the last valid and first invalid.
      applyStimulus(0, 0, 8'd0, 8'h00, 1, 0, 8'd25, 8'h00, ga, gb);
      applyStimulus(1, 1, 8'(DEPTH - 1), 8'hC3, 1, 1, 8'(DEPTH), 8'h99, ga, gb);
      applyStimulus(1, 0, 8'(DEPTH - 1), 8'h00, 0, 0, 8'd0, 8'h00, ga, gb);

      randomTraffic(300);

      // Reset while a response is outstanding, then verify RAM was cleared.
      applyStimulus(1, 1, 8'd2, 8'hE1, 1, 0, 8'd6, 8'h00, ga, gb);
      doReset();
      applyStimulus(1, 0, 8'd4, 8'h00, 1, 0, 8'd7, 8'h00, ga, gb);
      applyStimulus(1, 0, 8'd2, 8'h00, 1, 0, 8'd9, 8'h00, ga, gb);

      randomTraffic(150);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
